trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter: CSR_NONE, default 12'h000, CSR address that encodes "no CSR access".
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 exc_req  in  1  synchronous exception from executrol, level, sampled in IDLE only.
REQ-005 exc_cause  in  32  mcause code for exc_req.
REQ-006 exc_pc  in  32  PC of faulting instruction.
REQ-007 mret_req  in  1  MRET in execute, sampled in IDLE only.
REQ-008 irq_ext  in  1  machine external interrupt, level.
REQ-009 irq_pc  in  32  PC of instruction squashed in EX when an interrupt is taken.
REQ-010 ex_csr_waddr  in  12  executrol CSR write address (CSR_NONE = no write).
REQ-011 ex_csr_wdata  in  32  executrol CSR write data.
REQ-012 id_csr_raddr  in  12  decode CSR read address.
REQ-013 csr_rdata  in  32  CSR file combinational read data.
REQ-014 csr_raddr  out  12  CSR file read address.
REQ-015 csr_waddr  out  12  CSR file write address.
REQ-016 csr_wdata  out  32  CSR file write data.
REQ-017 busy  out  1  pipeline stall, high whenever state != IDLE.
REQ-018 flush  out  1  one-cycle pulse in the cycle an event is accepted.
REQ-019 redirect_valid / redirect_pc  out  1 / 32  one-cycle PC redirect request and target.

Function
REQ-020 CSR addresses SHALL be fixed: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
REQ-021 In IDLE with no accepted event: csr_raddr=id_csr_raddr, csr_waddr=ex_csr_waddr, csr_wdata=ex_csr_wdata (pass-through).
REQ-022 Acceptance priority in IDLE SHALL be exc_req > mret_req > (irq_ext AND mie_q); at most one event per cycle.
REQ-023 Accept cycle: flush=1, csr_waddr=CSR_NONE (same-cycle executrol write dropped), csr_raddr=id_csr_raddr; latch cause_q/epc_q (exception: exc_cause/exc_pc; interrupt: 32'h8000000B/irq_pc); trap sets mie_q=0.
REQ-024 Trap states, one cycle each: SAVE_EPC (write mepc=epc_q, read mtvec -> mtvec_q) -> SAVE_CAUSE (write mcause=cause_q, read mstatus -> mstatus_q) -> UPD_STATUS -> REDIRECT -> IDLE.
REQ-025 UPD_STATUS SHALL write mstatus = mstatus_q with bit7(MPIE)=mstatus_q[3], bit3(MIE)=0, bits12:11(MPP)=2'b11, other bits unchanged.
REQ-026 MRET states: MRET_EPC (read mepc -> epc_q) -> MRET_RDST (read mstatus -> mstatus_q) -> MRET_WRST (write mstatus: MIE=mstatus_q[7], MPIE=1, MPP=2'b11; mie_q<=mstatus_q[7]) -> REDIRECT -> IDLE.
REQ-027 The block SHALL never drive csr_waddr==csr_raddr (other than CSR_NONE) in the same cycle; read and write of one CSR occur in different states.
REQ-028 In all non-IDLE states unused CSR ports SHALL be CSR_NONE; executrol and decode CSR requests are ignored (stalled by busy).
REQ-029 REDIRECT: redirect_valid=1; MRET target = {epc_q[31:2],2'b00}; trap target = {mtvec_q[31:2],2'b00}, plus 4*cause_q[30:0] (32-bit wrap) when mtvec_q[1:0]==2'b01 and cause_q[31]==1; mtvec modes 2'b10/2'b11 treated as direct.
REQ-030 mie_q SHALL also load ex_csr_wdata[3] whenever a pass-through write to 0x300 occurs in IDLE.
REQ-031 Total occupancy: trap 5 cycles (accept + 4), MRET 5 cycles; next event acceptable in the cycle after REDIRECT.
REQ-032 irq_ext held high while mie_q=0 SHALL be ignored until mie_q=1; exc_req/mret_req asserted while busy SHALL be ignored.

Reset
REQ-033 On rst=1 at a clock edge: state=IDLE, mie_q=0, all latched registers 0, flush=0, redirect_valid=0, redirect_pc=0; reset mid-sequence aborts with no further CSR write and no redirect; pass-through active the cycle after rst falls.

Verification
REQ-034 mtvec=0x80000100, mstatus=0x8; exc_req cause=2, pc=0x80000040 -> mepc=0x80000040, mcause=2, mstatus=0x1880, redirect to 0x80000100 at accept+4.
REQ-035 mtvec=0x80000101, mie_q=1, irq_ext=1, irq_pc=0x200 -> mcause=0x8000000B, mepc=0x200, redirect 0x8000012C.
REQ-036 mepc=0x204, mstatus=0x1880; mret_req -> mstatus=0x1888, mie_q=1, redirect 0x204 at accept+4.
REQ-037 exc_req, mret_req, irq_ext all high with mie_q=1 -> exception taken; ex_csr write in accept cycle not seen on csr_waddr.
REQ-038 rst asserted in SAVE_CAUSE -> no mstatus write, redirect_valid stays 0, busy=0 next cycle; pass-through write of 0x8 to 0x300 then irq_ext=1 -> interrupt accepted.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap/MRET sequencer: arbitrates exceptions, MRET and the external
// interrupt, then walks the CSR file one access per cycle before redirecting fetch.
module trap_ctrl #(
  parameter logic [11:0] CSR_NONE = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [31:0] exc_cause,
  input  logic [31:0] exc_pc,
  input  logic        mret_req,
  input  logic        irq_ext,
  input  logic [31:0] irq_pc,
  input  logic [11:0] ex_csr_waddr,
  input  logic [31:0] ex_csr_wdata,
  input  logic [11:0] id_csr_raddr,
  input  logic [31:0] csr_rdata,
  output logic [11:0] csr_raddr,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        busy,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [31:0] IRQ_CAUSE   = 32'h8000_000B;

  typedef enum logic [2:0] {
    S_IDLE, S_SAVE_EPC, S_SAVE_CAUSE, S_UPD_STATUS,
    S_MRET_EPC, S_MRET_RDST, S_MRET_WRST, S_REDIRECT
  } state_t;

  state_t      state_q, state_d;
  logic        mie_q, mret_q;
  logic [31:0] cause_q, epc_q, mtvec_q, mstatus_q;

  logic        in_idle, take_exc, take_mret, take_irq;
  logic [31:0] trap_status, mret_status, trap_target;

  assign in_idle   = (state_q == S_IDLE);
  assign take_exc  = in_idle & exc_req;
  assign take_mret = in_idle & ~exc_req & mret_req;
  assign take_irq  = in_idle & ~exc_req & ~mret_req & irq_ext & mie_q;

  // Trap: MPIE<=MIE, MIE<=0, MPP<=M. MRET: MIE<=MPIE, MPIE<=1, MPP<=M.
  assign trap_status = {mstatus_q[31:13], 2'b11, mstatus_q[10:8], mstatus_q[3],
                        mstatus_q[6:4], 1'b0, mstatus_q[2:0]};
  assign mret_status = {mstatus_q[31:13], 2'b11, mstatus_q[10:8], 1'b1,
                        mstatus_q[6:4], mstatus_q[7], mstatus_q[2:0]};

  // Vectored mode only applies to interrupts; the offset wraps at 32 bits.
  assign trap_target = {mtvec_q[31:2], 2'b00} +
                       (((mtvec_q[1:0] == 2'b01) && cause_q[31]) ? {cause_q[29:0], 2'b00} : 32'h0);

  assign busy = ~in_idle;

  always_comb begin
    state_d        = state_q;
    csr_raddr      = CSR_NONE;
    csr_waddr      = CSR_NONE;
    csr_wdata      = '0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      S_IDLE: begin
        csr_raddr = id_csr_raddr;
        csr_wdata = ex_csr_wdata;
        if (take_exc || take_irq) begin
          flush   = 1'b1;
          state_d = S_SAVE_EPC;
        end else if (take_mret) begin
          flush   = 1'b1;
          state_d = S_MRET_EPC;
        end else begin
          csr_waddr = ex_csr_waddr;
        end
      end
      S_SAVE_EPC: begin
        csr_waddr = CSR_MEPC;
        csr_wdata = epc_q;
        csr_raddr = CSR_MTVEC;
        state_d   = S_SAVE_CAUSE;
      end
      S_SAVE_CAUSE: begin
        csr_waddr = CSR_MCAUSE;
        csr_wdata = cause_q;
        csr_raddr = CSR_MSTATUS;
        state_d   = S_UPD_STATUS;
      end
      S_UPD_STATUS: begin
        csr_waddr = CSR_MSTATUS;
        csr_wdata = trap_status;
        state_d   = S_REDIRECT;
      end
      S_MRET_EPC: begin
        csr_raddr = CSR_MEPC;
        state_d   = S_MRET_RDST;
      end
      S_MRET_RDST: begin
        csr_raddr = CSR_MSTATUS;
        state_d   = S_MRET_WRST;
      end
      S_MRET_WRST: begin
        csr_waddr = CSR_MSTATUS;
        csr_wdata = mret_status;
        state_d   = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = mret_q ? {epc_q[31:2], 2'b00} : trap_target;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mie_q     <= 1'b0;
      mret_q    <= 1'b0;
      cause_q   <= '0;
      epc_q     <= '0;
      mtvec_q   <= '0;
      mstatus_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (take_exc || take_irq) begin
            cause_q <= take_exc ? exc_cause : IRQ_CAUSE;
            epc_q   <= take_exc ? exc_pc : irq_pc;
            mie_q   <= 1'b0;
            mret_q  <= 1'b0;
          end else if (take_mret) begin
            mret_q <= 1'b1;
          end else if (ex_csr_waddr == CSR_MSTATUS) begin
            mie_q <= ex_csr_wdata[3];
          end
        end
        S_SAVE_EPC:   mtvec_q   <= csr_rdata;
        S_SAVE_CAUSE: mstatus_q <= csr_rdata;
        S_MRET_EPC:   epc_q     <= csr_rdata;
        S_MRET_RDST:  mstatus_q <= csr_rdata;
        S_MRET_WRST:  mie_q     <= mstatus_q[7];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: a CSR-file stand-in, a transaction-level model that expands
// each accepted event into its expected cycle sequence, and directed scenarios.
module tb_trap_ctrl;

  localparam logic [11:0] NONE      = 12'h000;
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc_req = 1'b0, mret_req = 1'b0, irq_ext = 1'b0;
  logic [31:0] exc_cause = '0, exc_pc = '0, irq_pc = '0;
  logic [11:0] ex_csr_waddr = NONE, id_csr_raddr = NONE;
  logic [31:0] ex_csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic [11:0] csr_raddr, csr_waddr;
  logic [31:0] csr_wdata, redirect_pc;
  logic        busy, flush, redirect_valid;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  trap_ctrl #(.CSR_NONE(NONE)) dut (
    .clk(clk), .rst(rst),
    .exc_req(exc_req), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .mret_req(mret_req), .irq_ext(irq_ext), .irq_pc(irq_pc),
    .ex_csr_waddr(ex_csr_waddr), .ex_csr_wdata(ex_csr_wdata),
    .id_csr_raddr(id_csr_raddr), .csr_rdata(csr_rdata),
    .csr_raddr(csr_raddr), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .busy(busy), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // Clock / watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // CSR file stand-in
  logic [31:0] csr_mem [0:4095];
  assign csr_rdata = csr_mem[csr_raddr];
  always @(posedge clk) if (csr_waddr != NONE) csr_mem[csr_waddr] <= csr_wdata;

  // Model: expected output record per cycle
  typedef struct {
    logic [11:0] raddr;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
    logic        mie_set;
    logic        mie_val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl_csr [0:4095];
  bit          mdl_mie = 1'b0;

  function automatic exp_t mk(input logic [11:0] ra, input logic [11:0] wa,
                              input logic [31:0] wd, input logic rv,
                              input logic [31:0] rpc, input logic ms, input logic mv);
    exp_t e;
    e.raddr = ra; e.waddr = wa; e.wdata = wd; e.busy = 1'b1; e.flush = 1'b0;
    e.rv = rv; e.rpc = rpc; e.mie_set = ms; e.mie_val = mv;
    return e;
  endfunction

  task automatic model_trap(input logic [31:0] cause, input logic [31:0] pc);
    logic [31:0] ms, tv, ns, tgt;
    ms = mdl_csr[A_MSTATUS];
    tv = mdl_csr[A_MTVEC];
    ns = ms;
    ns[7] = ms[3];
    ns[3] = 1'b0;
    ns[12:11] = 2'b11;
    tgt = {tv[31:2], 2'b00};
    if (tv[1:0] == 2'b01 && cause[31]) tgt = tgt + 32'(cause[30:0]) * 32'd4;
    exp_q.push_back(mk(A_MTVEC,   A_MEPC,    pc,    1'b0, 32'h0, 1'b0, 1'b0));
    exp_q.push_back(mk(A_MSTATUS, A_MCAUSE,  cause, 1'b0, 32'h0, 1'b0, 1'b0));
    exp_q.push_back(mk(NONE,      A_MSTATUS, ns,    1'b0, 32'h0, 1'b0, 1'b0));
    exp_q.push_back(mk(NONE,      NONE,      32'h0, 1'b1, tgt,   1'b0, 1'b0));
    mdl_mie = 1'b0;
  endtask

  task automatic model_mret();
    logic [31:0] ep, ms, ns;
    ep = mdl_csr[A_MEPC];
    ms = mdl_csr[A_MSTATUS];
    ns = ms;
    ns[3] = ms[7];
    ns[7] = 1'b1;
    ns[12:11] = 2'b11;
    exp_q.push_back(mk(A_MEPC,    NONE,      32'h0, 1'b0, 32'h0, 1'b0, 1'b0));
    exp_q.push_back(mk(A_MSTATUS, NONE,      32'h0, 1'b0, 32'h0, 1'b0, 1'b0));
    exp_q.push_back(mk(NONE,      A_MSTATUS, ns,    1'b0, 32'h0, 1'b1, ms[7]));
    exp_q.push_back(mk(NONE,      NONE,      32'h0, 1'b1, {ep[31:2], 2'b00}, 1'b0, 1'b0));
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      bit   bad;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e = mk(id_csr_raddr, ex_csr_waddr, ex_csr_wdata, 1'b0, 32'h0, 1'b0, 1'b0);
        e.busy = 1'b0;
        if (exc_req || mret_req || (irq_ext && mdl_mie)) begin
          e.flush = 1'b1;
          e.waddr = NONE;
          if (exc_req)       model_trap(exc_cause, exc_pc);
          else if (mret_req) model_mret();
          else               model_trap(32'h8000_000B, irq_pc);
        end
      end
      bad = (busy !== e.busy) || (flush !== e.flush) || (redirect_valid !== e.rv) ||
            (redirect_pc !== e.rpc) || (csr_raddr !== e.raddr) || (csr_waddr !== e.waddr) ||
            ((e.waddr != NONE) && (csr_wdata !== e.wdata));
      n_vec++;
      if (bad) begin
        n_err++;
        $display("FAIL cycle_check @%0d: got busy=%b flush=%b rv=%b rpc=%h ra=%h wa=%h wd=%h; want busy=%b flush=%b rv=%b rpc=%h ra=%h wa=%h wd=%h",
                 cyc, busy, flush, redirect_valid, redirect_pc, csr_raddr, csr_waddr, csr_wdata,
                 e.busy, e.flush, e.rv, e.rpc, e.raddr, e.waddr, e.wdata);
      end
      if (e.waddr != NONE) mdl_csr[e.waddr] = e.wdata;
      if (!e.busy && e.waddr == A_MSTATUS) mdl_mie = e.wdata[3];
      if (e.mie_set) mdl_mie = e.mie_val;
      if (rst) begin
        exp_q.delete();
        mdl_mie = 1'b0;
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    ex_csr_waddr = a;
    ex_csr_wdata = d;
    step();
    ex_csr_waddr = NONE;
    ex_csr_wdata = '0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  initial begin
    // Reset
    steps(2);
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_rv", {31'b0, redirect_valid}, 32'h0);
    check("rst_rpc", redirect_pc, 32'h0);
    step();

    // Synchronous exception, direct mtvec
    csr_write(A_MTVEC, 32'h8000_0100);
    csr_write(A_MSTATUS, 32'h8);
    exc_req = 1'b1; exc_cause = 32'd2; exc_pc = 32'h8000_0040;
    @(negedge clk);
    check("exc_flush", {31'b0, flush}, 32'h1);
    step();
    exc_req = 1'b0;
    steps(3);
    @(negedge clk);
    check("exc_rv", {31'b0, redirect_valid}, 32'h1);
    check("exc_rpc", redirect_pc, 32'h8000_0100);
    step();
    check("exc_mepc", csr_mem[A_MEPC], 32'h8000_0040);
    check("exc_mcause", csr_mem[A_MCAUSE], 32'd2);
    check("exc_mstatus", csr_mem[A_MSTATUS], 32'h1880);

    // Interrupt with vectored mtvec; irq held high afterwards must be ignored (mie=0)
    csr_write(A_MTVEC, 32'h8000_0101);
    csr_write(A_MSTATUS, 32'h8);
    irq_ext = 1'b1; irq_pc = 32'h200;
    @(negedge clk);
    check("irq_flush", {31'b0, flush}, 32'h1);
    steps(4);
    @(negedge clk);
    check("irq_rpc", redirect_pc, 32'h8000_012C);
    step();
    @(negedge clk);
    check("irq_masked_flush", {31'b0, flush}, 32'h0);
    check("irq_mcause", csr_mem[A_MCAUSE], 32'h8000_000B);
    check("irq_mepc", csr_mem[A_MEPC], 32'h200);
    step();
    irq_ext = 1'b0;

    // MRET restores MIE from MPIE
    csr_write(A_MEPC, 32'h204);
    csr_write(A_MSTATUS, 32'h1880);
    mret_req = 1'b1;
    @(negedge clk);
    check("mret_flush", {31'b0, flush}, 32'h1);
    step();
    mret_req = 1'b0;
    steps(3);
    @(negedge clk);
    check("mret_rpc", redirect_pc, 32'h204);
    step();
    check("mret_mstatus", csr_mem[A_MSTATUS], 32'h1888);
    irq_ext = 1'b1; irq_pc = 32'h500;
    @(negedge clk);
    check("mret_mie_irq", {31'b0, flush}, 32'h1);
    step();
    irq_ext = 1'b0;
    steps(4);

    // Simultaneous requests: exception wins, same-cycle executrol write dropped
    csr_write(A_MSTATUS, 32'h8);
    exc_req = 1'b1; exc_cause = 32'd5; exc_pc = 32'h300;
    mret_req = 1'b1; irq_ext = 1'b1; irq_pc = 32'h999;
    ex_csr_waddr = A_MTVEC; ex_csr_wdata = 32'hDEAD_0000;
    @(negedge clk);
    check("prio_waddr", {20'b0, csr_waddr}, 32'h0);
    step();
    ex_csr_waddr = NONE; ex_csr_wdata = '0; irq_ext = 1'b0;
    step();
    exc_req = 1'b0; mret_req = 1'b0;
    steps(2);
    @(negedge clk);
    check("prio_rpc", redirect_pc, 32'h8000_0100);
    step();
    check("prio_mcause", csr_mem[A_MCAUSE], 32'd5);
    check("prio_mtvec", csr_mem[A_MTVEC], 32'h8000_0101);

    // Reset in SAVE_CAUSE aborts; then pass-through write re-enables irq
    exc_req = 1'b1; exc_cause = 32'd7; exc_pc = 32'h400;
    step();
    exc_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ex_csr_waddr = A_MSTATUS; ex_csr_wdata = 32'h8;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_rv", {31'b0, redirect_valid}, 32'h0);
    check("abort_mstatus", csr_mem[A_MSTATUS], 32'h1880);
    check("abort_passthru", {20'b0, csr_waddr}, 32'h300);
    step();
    ex_csr_waddr = NONE; ex_csr_wdata = '0;
    irq_ext = 1'b1; irq_pc = 32'h600;
    @(negedge clk);
    check("abort_irq_flush", {31'b0, flush}, 32'h1);
    step();
    irq_ext = 1'b0;
    steps(5);
    check("abort_irq_mepc", csr_mem[A_MEPC], 32'h600);
    check("abort_irq_mstatus", csr_mem[A_MSTATUS], 32'h1880);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
